// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game-sequencing FSM for the Pong screen.
//   Decides when the graphics datapath animates or is frozen, when a ball is served,
//   and when a game starts or ends. Tracks remaining lives and a 2-digit BCD score.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   refr_tick         one-cycle pulse per frame (60 Hz)
//   btn[1:0]          paddle buttons, active-high, already synchronised
//   hit, miss         one-cycle pulses from the graphics block
//   gra_still         1 = freeze ball/paddle animation (decoded from state)
//   ball_serve        one-cycle pulse on the first PLAY cycle
//   game_over         high while in OVER (decoded from state)
//   lives[1:0]        remaining lives
//   score_d1/d0[3:0]  BCD score tens/units
//   state_o[2:0]      FSM state: NEWGAME=0, PLAY=1, NEWBALL=2, OVER=3
//   speed_lvl[1:0]    ball speed level 0..3
//
// Optional feature: define PONG_SPEEDUP_EN to build the hit counter that raises
// speed_lvl every HITS_PER_LVL accepted hits. Without it speed_lvl is tied to 0.

module pong_game_ctrl #(
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned DELAY_FRAMES = 120,
    parameter int unsigned HITS_PER_LVL = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refr_tick,
    input  logic [1:0] btn,
    input  logic       hit,
    input  logic       miss,
    output logic       gra_still,
    output logic       ball_serve,
    output logic       game_over,
    output logic [1:0] lives,
    output logic [3:0] score_d1,
    output logic [3:0] score_d0,
    output logic [2:0] state_o,
    output logic [1:0] speed_lvl
);

    localparam int unsigned TMR_W = 8;
    localparam int unsigned CNT_W = 4;

    // Elaboration-time parameter range check
    if (LIVES_INIT == 0 || LIVES_INIT > 3 || DELAY_FRAMES == 0 || DELAY_FRAMES > 255 ||
        HITS_PER_LVL == 0 || HITS_PER_LVL > 15) begin : g_bad_params
        $error("pong_game_ctrl: parameter out of range");
    end

    typedef enum logic [2:0] {
        NEWGAME = 3'd0,
        PLAY    = 3'd1,
        NEWBALL = 3'd2,
        OVER    = 3'd3
    } state_t;

    state_t             state;
    logic [TMR_W-1:0]   timer;
    logic               btn_any;
    logic               game_start;
    logic               hit_ok;
    logic [3:0]         inc_d1;
    logic [3:0]         inc_d0;

    assign btn_any    = |btn;
    assign game_start = (state == NEWGAME) && btn_any;
    // miss has priority over a coincident hit
    assign hit_ok     = (state == PLAY) && hit && !miss;

    assign gra_still  = (state != PLAY);
    assign game_over  = (state == OVER);
    assign state_o    = state;

    // BCD increment saturating at 99
    always_comb begin
        inc_d1 = score_d1;
        inc_d0 = score_d0;
        if (score_d0 != 4'd9) begin
            inc_d0 = score_d0 + 4'd1;
        end else if (score_d1 != 4'd9) begin
            inc_d0 = 4'd0;
            inc_d1 = score_d1 + 4'd1;
        end
    end

    // Game sequencing FSM with registered lives/score/timer/serve
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= NEWGAME;
            timer      <= '0;
            lives      <= 2'(LIVES_INIT);
            score_d1   <= 4'd0;
            score_d0   <= 4'd0;
            ball_serve <= 1'b0;
        end else begin
            ball_serve <= 1'b0;
            case (state)
                NEWGAME: begin
                    if (btn_any) begin
                        state      <= PLAY;
                        ball_serve <= 1'b1;
                        score_d1   <= 4'd0;
                        score_d0   <= 4'd0;
                        lives      <= 2'(LIVES_INIT);
                    end
                end
                PLAY: begin
                    if (miss) begin
                        timer <= TMR_W'(DELAY_FRAMES);
                        if (lives > 2'd1) begin
                            lives <= lives - 2'd1;
                            state <= NEWBALL;
                        end else begin
                            lives <= 2'd0;
                            state <= OVER;
                        end
                    end else if (hit) begin
                        score_d1 <= inc_d1;
                        score_d0 <= inc_d0;
                    end
                end
                NEWBALL: begin
                    // exit is judged on the registered timer, one cycle after it hits 0
                    if (timer == '0) begin
                        if (btn_any) begin
                            state      <= PLAY;
                            ball_serve <= 1'b1;
                        end
                    end else if (refr_tick) begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                OVER: begin
                    if (timer == '0) begin
                        state <= NEWGAME;
                    end else if (refr_tick) begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                default: begin
                    state <= NEWGAME;
                end
            endcase
        end
    end

`ifdef PONG_SPEEDUP_EN
    logic [CNT_W-1:0] hit_cnt;
    logic [1:0]       speed_q;

    // Speed level rises every HITS_PER_LVL accepted hits; only a new game clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt <= '0;
            speed_q <= 2'd0;
        end else if (game_start) begin
            hit_cnt <= '0;
            speed_q <= 2'd0;
        end else if (hit_ok) begin
            if (hit_cnt + CNT_W'(1) == CNT_W'(HITS_PER_LVL)) begin
                hit_cnt <= '0;
                if (speed_q != 2'd3) begin
                    speed_q <= speed_q + 2'd1;
                end
            end else begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
        end
    end

    assign speed_lvl = speed_q;
`else
    logic unused_ok;
    assign unused_ok = game_start ^ hit_ok;
    assign speed_lvl = 2'd0;
`endif

endmodule

// File: tb/tb_pong_game_ctrl.sv
module tb_pong_game_ctrl;

`ifdef PONG_SPEEDUP_EN
    localparam int SPD = 3;
`else
    localparam int SPD = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       refr_tick;
    logic [1:0] btn;
    logic       hit;
    logic       miss;
    logic       gra_still;
    logic       ball_serve;
    logic       game_over;
    logic [1:0] lives;
    logic [3:0] score_d1;
    logic [3:0] score_d0;
    logic [2:0] state_o;
    logic [1:0] speed_lvl;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] lv;
        logic [3:0] d1;
        logic [3:0] d0;
        logic       gs;
        logic       go;
        logic       bs;
        logic [1:0] sp;
    } snap_t;

    typedef struct {
        string tag;
        snap_t s;
    } exp_t;

    exp_t sb_q[$];

    pong_game_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .refr_tick  (refr_tick),
        .btn        (btn),
        .hit        (hit),
        .miss       (miss),
        .gra_still  (gra_still),
        .ball_serve (ball_serve),
        .game_over  (game_over),
        .lives      (lives),
        .score_d1   (score_d1),
        .score_d0   (score_d0),
        .state_o    (state_o),
        .speed_lvl  (speed_lvl)
    );

    always #5 clk = ~clk;

    // Expected snapshot built from the state; gra_still/game_over follow from it
    function automatic snap_t mk(input int st, input int lv, input int d1, input int d0,
                                 input bit bs, input int sp);
        snap_t s;
        s.st = 3'(st);
        s.lv = 2'(lv);
        s.d1 = 4'(d1);
        s.d0 = 4'(d0);
        s.gs = (st != 1);
        s.go = (st == 3);
        s.bs = bs;
        s.sp = 2'(sp);
        return s;
    endfunction

    function automatic snap_t cur();
        snap_t s;
        s = {state_o, lives, score_d1, score_d0, gra_still, game_over, ball_serve, speed_lvl};
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drive one cycle of stimulus; optionally queue the expected outcome and compare it
    task automatic step(input logic [1:0] b, input logic h, input logic m, input logic r,
                        input bit do_chk, input string tag, input snap_t e);
        exp_t x;
        btn = b; hit = h; miss = m; refr_tick = r;
        if (do_chk) sb_q.push_back('{tag, e});
        @(posedge clk);
        #1;
        if (do_chk) begin
            if (sb_q.size() == 0) begin
                check({tag, "_sb_empty"}, 32'd1, 32'd0);
            end else begin
                x = sb_q.pop_front();
                check(x.tag, 32'(cur()), 32'(x.s));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, "", '0);
    endtask

    // n refresh ticks, each followed by a quiet cycle, with btn held at b
    task automatic run_ticks(input int n, input logic [1:0] b);
        for (int i = 0; i < n; i++) begin
            step(b, 1'b0, 1'b0, 1'b1, 1'b0, "", '0);
            step(b, 1'b0, 1'b0, 1'b0, 1'b0, "", '0);
        end
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, "", '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; btn = 2'b00; hit = 1'b0; miss = 1'b0; refr_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(cur()), 32'(mk(0, 3, 0, 0, 0, 0)));
        reset = 1'b0;
        step(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, "newgame_idle", mk(0, 3, 0, 0, 0, 0));

        // game start, single serve pulse
        step(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, "start_play", mk(1, 3, 0, 0, 1, 0));
        step(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, "serve_once", mk(1, 3, 0, 0, 0, 0));
        step(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, "tick_ignored_play", mk(1, 3, 0, 0, 0, 0));

        hits(11);
        step(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, "score_12", mk(1, 3, 1, 2, 0, SPD));
        hits(7);
        step(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, "score_20_speed_sat", mk(1, 3, 2, 0, 0, SPD));

        // miss with btn held: NEWBALL, accepted on first cycle timer reaches 0
        step(2'b01, 1'b0, 1'b1, 1'b0, 1'b1, "miss_newball", mk(2, 2, 2, 0, 0, SPD));
        run_ticks(119, 2'b01);
        step(2'b01, 1'b0, 1'b0, 1'b1, 1'b1, "tick120_still_newball", mk(2, 2, 2, 0, 0, SPD));
        step(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, "newball_to_play", mk(1, 2, 2, 0, 1, SPD));
        step(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, "serve_single_held", mk(1, 2, 2, 0, 0, SPD));

        // hit and miss together: miss wins
        step(2'b00, 1'b1, 1'b1, 1'b0, 1'b1, "hit_miss_same", mk(2, 1, 2, 0, 0, SPD));
        step(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, "hit_ignored_newball", mk(2, 1, 2, 0, 0, SPD));
        run_ticks(120, 2'b00);
        step(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, "newball_wait_btn", mk(2, 1, 2, 0, 0, SPD));
        step(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, "newball_btn_play", mk(1, 1, 2, 0, 1, SPD));

        // final miss -> OVER -> NEWGAME with score retained
        step(2'b00, 1'b0, 1'b1, 1'b0, 1'b1, "last_miss_over", mk(3, 0, 2, 0, 0, SPD));
        run_ticks(119, 2'b11);
        step(2'b11, 1'b0, 1'b0, 1'b1, 1'b1, "over_tick120", mk(3, 0, 2, 0, 0, SPD));
        step(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, "over_to_newgame", mk(0, 0, 2, 0, 0, SPD));
        step(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, "newgame_hold_score", mk(0, 0, 2, 0, 0, SPD));
        step(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, "restart", mk(1, 3, 0, 0, 1, 0));

        // saturation at 99
        hits(98);
        step(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, "score_99", mk(1, 3, 9, 9, 0, SPD));
        step(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, "score_99_sat", mk(1, 3, 9, 9, 0, SPD));

        // asynchronous reset while in NEWBALL
        step(2'b00, 1'b0, 1'b1, 1'b0, 1'b1, "miss_before_reset", mk(2, 2, 9, 9, 0, SPD));
        run_ticks(5, 2'b00);
        reset = 1'b1;
        #1;
        check("async_reset_state", 32'(state_o), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, "post_reset", mk(0, 3, 0, 0, 0, 0));
        idle(2);
        step(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, "no_pending_serve", mk(0, 3, 0, 0, 0, 0));

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
